// File: rtl/word_serial_tx.sv
// ---------------------------------------------------------------------------
// word_serial_tx
// Sends a parallel word out on one serial line. Each frame is a low start
// bit, the data bits LSB first, and a high stop bit. The line idles high.
// The partner receiver rebuilds the word for LED/HEX display.
//
// Optional build macro: WORD_SERIAL_TX_PARITY_EN
//   When defined, an even-parity bit (XOR of the latched word) is sent
//   between the last data bit and the stop bit.
//
// Parameters:
//   WIDTH         data word width in bits (1..16)
//   CLKS_PER_BIT  clk cycles per serial bit (minimum 2)
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   en       in   global enable; low freezes the bit timer and the FSM
//   load     in   level request to send data_in
//   data_in  in   word to send (WIDTH bits)
//   ready    out  high in IDLE while en=1; a frame starts on ready & load
//   busy     out  high from acceptance until the stop bit ends
//   tx       out  serial line, idle high
//   bit_idx  out  index of the data bit on tx; 0 outside DATA
//   done     out  one-cycle pulse on the last cycle of the stop bit
// ---------------------------------------------------------------------------
module word_serial_tx #(
    parameter int WIDTH        = 5,
    parameter int CLKS_PER_BIT = 5000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             busy,
    output logic             tx,
    output logic [3:0]       bit_idx,
    output logic             done
);

    localparam int            TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TC       = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_IDX = 4'(WIDTH - 1);

`ifdef WORD_SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           r_state, w_state_next;
    logic [TW-1:0]    r_timer, w_timer_next;
    logic [WIDTH-1:0] r_shift, w_shift_next;
    logic [3:0]       r_bit_idx, w_bit_idx_next;
    logic             r_tx, w_tx_next;
    logic             r_busy;
    logic             r_live;
    logic             w_ready;
    logic             w_tc;
    logic             w_done;
`ifdef WORD_SERIAL_TX_PARITY_EN
    logic             r_parity, w_parity_next;
`endif

    // r_live keeps ready low until the first clock edge after reset release,
    // since the FSM already sits in IDLE while reset is held.
    assign w_ready = r_live && en && (r_state == S_IDLE);
    assign w_tc    = (r_timer == TC);

    // Next-state logic. Nothing moves while en is low, so the frame resumes
    // exactly where it paused. tx is derived from the next state so the
    // registered line changes on the same edge as the state.
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_done         = 1'b0;
`ifdef WORD_SERIAL_TX_PARITY_EN
        w_parity_next  = r_parity;
`endif
        if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_ready && load) begin
                        w_state_next  = S_START;
                        w_timer_next  = '0;
                        w_shift_next  = data_in;
`ifdef WORD_SERIAL_TX_PARITY_EN
                        w_parity_next = ^data_in;
`endif
                    end
                end
                S_START: begin
                    w_timer_next = w_tc ? '0 : r_timer + TW'(1);
                    if (w_tc) w_state_next = S_DATA;
                end
                S_DATA: begin
                    w_timer_next = w_tc ? '0 : r_timer + TW'(1);
                    if (w_tc) begin
                        w_shift_next = r_shift >> 1;
                        if (r_bit_idx == LAST_IDX) begin
                            w_bit_idx_next = '0;
`ifdef WORD_SERIAL_TX_PARITY_EN
                            w_state_next   = S_PARITY;
`else
                            w_state_next   = S_STOP;
`endif
                        end else begin
                            w_bit_idx_next = r_bit_idx + 4'd1;
                        end
                    end
                end
`ifdef WORD_SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    w_timer_next = w_tc ? '0 : r_timer + TW'(1);
                    if (w_tc) w_state_next = S_STOP;
                end
`endif
                S_STOP: begin
                    w_timer_next = w_tc ? '0 : r_timer + TW'(1);
                    if (w_tc) begin
                        w_state_next = S_IDLE;
                        w_done       = 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end

        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef WORD_SERIAL_TX_PARITY_EN
            S_PARITY: w_tx_next = w_parity_next;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    // State register; reset aborts any frame and forces the line high at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_live    <= 1'b0;
`ifdef WORD_SERIAL_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
            r_busy    <= (w_state_next != S_IDLE);
            r_live    <= 1'b1;
`ifdef WORD_SERIAL_TX_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    assign ready   = w_ready;
    assign busy    = r_busy;
    assign tx      = r_tx;
    assign bit_idx = r_bit_idx;
    assign done    = w_done;

endmodule

// File: tb/tb_word_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_word_serial_tx
// Self-checking bench for word_serial_tx (WIDTH=5, CLKS_PER_BIT=4).
// Expected line levels and bit indices for every enabled bit-timer cycle are
// queued when a frame is requested and popped as the DUT shifts them out.
// ---------------------------------------------------------------------------
module tb_word_serial_tx;

    localparam int WIDTH = 5;
    localparam int CPB   = 4;
`ifdef WORD_SERIAL_TX_PARITY_EN
    localparam int FRAME = (WIDTH + 3) * CPB;
`else
    localparam int FRAME = (WIDTH + 2) * CPB;
`endif

    logic             clk;
    logic             reset_n;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             busy;
    logic             tx;
    logic [3:0]       bit_idx;
    logic             done;

    int testsRun    = 0;
    int testsFailed = 0;

    logic       expTx[$];
    logic [3:0] expIdx[$];

    word_serial_tx #(
        .WIDTH       (WIDTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (en),
        .load   (load),
        .data_in(data_in),
        .ready  (ready),
        .busy   (busy),
        .tx     (tx),
        .bit_idx(bit_idx),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the per-cycle line level and bit index of one whole frame.
    task automatic pushFrame(input logic [WIDTH-1:0] word);
        for (int k = 0; k < CPB; k++) begin expTx.push_back(1'b0); expIdx.push_back(4'd0); end
        for (int i = 0; i < WIDTH; i++)
            for (int k = 0; k < CPB; k++) begin expTx.push_back(word[i]); expIdx.push_back(4'(i)); end
`ifdef WORD_SERIAL_TX_PARITY_EN
        for (int k = 0; k < CPB; k++) begin expTx.push_back(^word); expIdx.push_back(4'd0); end
`endif
        for (int k = 0; k < CPB; k++) begin expTx.push_back(1'b1); expIdx.push_back(4'd0); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b1; load = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        testsRun++; if (tx !== 1'b1)      begin testsFailed++; $display("[TB] FAIL reset_tx got %b want 1", tx); end
        testsRun++; if (busy !== 1'b0)    begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        testsRun++; if (done !== 1'b0)    begin testsFailed++; $display("[TB] FAIL reset_done got %b want 0", done); end
        testsRun++; if (ready !== 1'b0)   begin testsFailed++; $display("[TB] FAIL reset_ready got %b want 0", ready); end
        testsRun++; if (bit_idx !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_bit_idx got %0d want 0", bit_idx); end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        testsRun++; if (ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL ready_before_edge got %b want 0", ready); end
        @(negedge clk);
        testsRun++; if (ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL ready_after_release got %b want 1", ready); end
        en = 1'b0; #1;
        testsRun++; if (ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL ready_en_low got %b want 0", ready); end
        en = 1'b1;
    endtask

    task automatic test_basic_frame();
        int busyCount = 0; int doneCount = 0; int doneAt = 0;
        logic e; logic [3:0] ei;
        pushFrame(5'b10110);
        @(posedge clk); #1 data_in = 5'b10110; load = 1'b1;
        @(posedge clk); #1 load = 1'b0; data_in = 5'b01001;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) break;
            busyCount++;
            testsRun++;
            if (expTx.size() == 0) begin testsFailed++; $display("[TB] FAIL basic_underflow at cycle %0d", busyCount); end
            else begin
                e = expTx.pop_front(); ei = expIdx.pop_front();
                if (tx !== e) begin testsFailed++; $display("[TB] FAIL basic_tx cycle %0d got %b want %b", busyCount, tx, e); end
                testsRun++;
                if (bit_idx !== ei) begin testsFailed++; $display("[TB] FAIL basic_bit_idx cycle %0d got %0d want %0d", busyCount, bit_idx, ei); end
            end
            if (done) begin doneCount++; doneAt = busyCount; end
        end
        testsRun++; if (busyCount != FRAME) begin testsFailed++; $display("[TB] FAIL basic_busy_len got %0d want %0d", busyCount, FRAME); end
        testsRun++; if (doneCount != 1 || doneAt != FRAME) begin testsFailed++; $display("[TB] FAIL basic_done got %0d pulses at %0d want 1 at %0d", doneCount, doneAt, FRAME); end
        testsRun++; if (expTx.size() != 0) begin testsFailed++; $display("[TB] FAIL basic_leftover got %0d want 0", expTx.size()); end
        expTx.delete(); expIdx.delete();
    endtask

    task automatic test_pause();
        int busyCount = 0; int enCount = 0; int pausedSeen = 0; int doneCount = 0; int doneAt = 0;
        logic e; logic lastExp;
        lastExp = 1'b1;
        pushFrame(5'b10110);
        @(posedge clk); #1 data_in = 5'b10110; load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) break;
            busyCount++;
            testsRun++;
            if (!en) begin
                pausedSeen++;
                if (tx !== lastExp) begin testsFailed++; $display("[TB] FAIL pause_hold cycle %0d got %b want %b", busyCount, tx, lastExp); end
                if (pausedSeen == 10) en = 1'b1;
            end else if (expTx.size() == 0) begin
                testsFailed++; $display("[TB] FAIL pause_underflow at cycle %0d", busyCount);
            end else begin
                enCount++;
                e = expTx.pop_front(); void'(expIdx.pop_front()); lastExp = e;
                if (tx !== e) begin testsFailed++; $display("[TB] FAIL pause_tx cycle %0d got %b want %b", busyCount, tx, e); end
                if (enCount == 3 * CPB + 2) en = 1'b0;
            end
            if (done) begin doneCount++; doneAt = busyCount; end
        end
        en = 1'b1;
        testsRun++; if (busyCount != FRAME + 10) begin testsFailed++; $display("[TB] FAIL pause_len got %0d want %0d", busyCount, FRAME + 10); end
        testsRun++; if (doneCount != 1 || doneAt != FRAME + 10) begin testsFailed++; $display("[TB] FAIL pause_done got %0d pulses at %0d want 1 at %0d", doneCount, doneAt, FRAME + 10); end
        expTx.delete(); expIdx.delete();
    endtask

    task automatic test_ignore_busy();
        int busyCount = 0; int lateBusy = 0;
        logic e;
        pushFrame(5'b10110);
        @(posedge clk); #1 data_in = 5'b10110; load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) break;
            busyCount++;
            if (busyCount == 6) begin load = 1'b1; data_in = 5'b00001; end
            if (busyCount == 9) load = 1'b0;
            testsRun++;
            if (expTx.size() == 0) begin testsFailed++; $display("[TB] FAIL ignore_underflow at cycle %0d", busyCount); end
            else begin
                e = expTx.pop_front(); void'(expIdx.pop_front());
                if (tx !== e) begin testsFailed++; $display("[TB] FAIL ignore_tx cycle %0d got %b want %b", busyCount, tx, e); end
            end
        end
        repeat (12) begin @(negedge clk); if (busy) lateBusy++; end
        testsRun++; if (busyCount != FRAME) begin testsFailed++; $display("[TB] FAIL ignore_len got %0d want %0d", busyCount, FRAME); end
        testsRun++; if (lateBusy != 0) begin testsFailed++; $display("[TB] FAIL ignore_second_frame got %0d busy cycles want 0", lateBusy); end
        expTx.delete(); expIdx.delete();
    endtask

    task automatic test_back_to_back();
        int cyc = 0; int doneCount = 0; int done1 = 0; int done2 = 0; int idleBetween = 0;
        logic e;
        pushFrame(5'b11111);
        pushFrame(5'b11111);
        @(posedge clk); #1 data_in = 5'b11111; load = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            cyc++;
            if (busy) begin
                testsRun++;
                if (expTx.size() == 0) begin testsFailed++; $display("[TB] FAIL b2b_underflow at cycle %0d", cyc); end
                else begin
                    e = expTx.pop_front(); void'(expIdx.pop_front());
                    if (tx !== e) begin testsFailed++; $display("[TB] FAIL b2b_tx cycle %0d got %b want %b", cyc, tx, e); end
                end
            end else if (doneCount == 1) begin
                idleBetween++;
                testsRun++;
                if (tx !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_idle_tx got %b want 1", tx); end
            end
            if (done) begin
                doneCount++;
                if (doneCount == 1) done1 = cyc;
                if (doneCount == 2) begin done2 = cyc; load = 1'b0; end
            end
            if (doneCount >= 2 && !busy) break;
        end
        load = 1'b0;
        testsRun++; if (doneCount != 2) begin testsFailed++; $display("[TB] FAIL b2b_done_count got %0d want 2", doneCount); end
        testsRun++; if (done2 - done1 != FRAME + 1) begin testsFailed++; $display("[TB] FAIL b2b_done_gap got %0d want %0d", done2 - done1, FRAME + 1); end
        testsRun++; if (idleBetween != 1) begin testsFailed++; $display("[TB] FAIL b2b_idle_cycles got %0d want 1", idleBetween); end
        testsRun++; if (expTx.size() != 0) begin testsFailed++; $display("[TB] FAIL b2b_leftover got %0d want 0", expTx.size()); end
        expTx.delete(); expIdx.delete();
    endtask

    task automatic test_reset_mid_frame();
        int busyCount = 0; int doneSeen = 0;
        @(posedge clk); #1 data_in = 5'b10100; load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy) busyCount++;
            if (done) doneSeen++;
            if (busyCount == 10) break;
        end
        testsRun++; if (tx !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_pre_tx got %b want 0", tx); end
        reset_n = 1'b0; #1;
        testsRun++; if (tx !== 1'b1)   begin testsFailed++; $display("[TB] FAIL midreset_tx got %b want 1", tx); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
        repeat (3) begin @(negedge clk); if (done) doneSeen++; end
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) begin @(negedge clk); if (done) doneSeen++; end
        testsRun++; if (doneSeen != 0) begin testsFailed++; $display("[TB] FAIL midreset_done got %0d want 0", doneSeen); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_after_busy got %b want 0", busy); end
        testsRun++; if (ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_ready got %b want 1", ready); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_pause();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/word_serial_tx.md
Name: word_serial_tx

Overview:
- Reads a parallel word, e.g. the WIDTH-bit value held by the switch-capture register, and transmits it on a single serial line.
- Frame: start bit, data LSB first, stop bit.
- Partner is a serial receiver that rebuilds the word into a register for LED/HEX display.
- Sits between the captured-word register and a GPIO/LED pin; one instance per link.

Parameters:
- WIDTH, 5, data word width in bits (1..16).
- CLKS_PER_BIT, 5000000, clk cycles per serial bit (10 bit/s at 50 MHz, visible on an LED); minimum 2.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; low pauses the bit timer and FSM.
- load  in  1  request to transmit data_in; level-sensitive.
- data_in  in  WIDTH  word to transmit.
- ready  out  1  high when IDLE and en=1; load accepted on a cycle with ready&load.
- busy  out  1  high from acceptance until end of stop bit.
- tx  out  1  serial line, idle high.
- bit_idx  out  4  index of data bit currently on tx (0..WIDTH-1); 0 outside DATA.
- done  out  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: tx=1, busy=0, done=0, bit_idx=0, ready=0 while asserted.
  - Internal state: FSM=IDLE, shift register=0, bit timer=0.
- Reset release: ready rises on the first clk edge after release, provided en=1.
- FSM states: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- IDLE:
  - tx=1.
  - On ready&load, data_in is latched into the shift register, FSM goes to START and the timer clears.
  - data_in changes after acceptance have no effect.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state; advances only when en=1.
  - Each state lasts exactly CLKS_PER_BIT enabled cycles.
  - Timer width is clog2(CLKS_PER_BIT).
- START: tx=0.
- DATA:
  - tx = shift register bit 0.
  - At timer terminal count: shift right by 1 and increment bit_idx.
  - After bit WIDTH-1, go to PARITY if compiled in, else STOP.
- STOP:
  - tx=1.
  - At terminal count: done=1 for that cycle, busy falls on the next edge, FSM goes to IDLE.
- Latency: tx falls on the clk edge that accepts load (registered tx; 1 cycle after load is sampled).
- Frame length: (WIDTH+2)*CLKS_PER_BIT enabled cycles.
- Back-to-back frames:
  - load held high gives ready=1 on the cycle after done, and the next frame is accepted there.
  - One idle-high cycle minimum between frames.
- en=0 mid-frame:
  - Timer, FSM, shift register and bit_idx all freeze; tx holds its current level.
  - Resumes exactly where it stopped.
  - ready=0 while en=0.
- load while busy is ignored; there is no queueing.
- reset_n low mid-frame aborts the frame immediately (tx=1 asynchronously); no done pulse.
- busy and tx are registered outputs; ready is combinational from state and en.

Optional Feature:
- Macro: WORD_SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx in PARITY = XOR of the latched word (even parity).
  - Frame length becomes (WIDTH+3)*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic.

Test Plan:
- Reset/idle: reset_n=0 for 3 cycles, then release with en=1 -> tx=1, busy=0, done=0, ready=1 from the cycle after release.
- Basic frame: WIDTH=5, CLKS_PER_BIT=4, data_in=5'b10110, one-cycle load, en=1 ->
  - tx sequence per 4 cycles: 0,0,1,1,0,1,1 (start, LSB-first data, stop).
  - busy high for 28 cycles; done pulse at cycle 28.
- Pause: same frame with en=0 for 10 cycles during data bit 2 -> tx holds 1 for those 10 cycles, frame ends at cycle 38, bit sequence unchanged.
- Ignore while busy: load with data_in=5'b00001 while busy -> ignored, current frame bits unchanged, no second frame.
- Back-to-back: load held high with data_in=5'b11111 -> consecutive frames separated by exactly one idle-high cycle; done pulses 29 cycles apart.
- Reset mid-frame plus parity:
  - reset_n low at cycle 10 of a frame -> tx=1 immediately, busy=0, no done.
  - With WORD_SERIAL_TX_PARITY_EN and data_in=5'b10110 -> parity bit=1, frame length 32 cycles.
